cntr_ring_scheduler: RTL and testbench
======================================

// Module: cntr_ring_scheduler
// PURPOSE
//  Owns NUM_CNTRS event counters on the register ring. Per-counter update/decrement pulses go into small
//  signed delta accumulators. A round-robin scheduler folds these deltas into the counter store through
//  one shared access port. Register-ring reads and writes take that port with priority. Sits in-line
//  on the ring between upstream and downstream register blocks.
// PARAMETERS
//  NUM_CNTRS       2   number of counters (1..16)
//  REG_WIDTH       16  counter width; equals ring data width
//  DELTA_WIDTH     4   signed accumulator width per counter (>=3)
//  REG_ADDR_WIDTH  5   low address bits decoded locally
//  TAG             0   required value of reg_addr_in[15:REG_ADDR_WIDTH]
//  RESET_ON_READ   0   1: a ring read of a counter zeroes it
// PORTS
//  clk              in   1            system clock
//  reset            in   1            asynchronous, active-high reset
//  reg_req_in       in   1            ring request valid (one-cycle pulse per transaction)
//  reg_ack_in       in   1            request already serviced upstream
//  reg_rd_wr_L_in   in   1            1=read, 0=write
//  reg_addr_in      in   16           ring address
//  reg_data_in      in   16           ring write data / upstream read data
//  reg_src_in       in   16           requester id, forwarded unchanged
//  reg_req_out      out  1            registered ring outputs, same meaning as inputs
//  reg_ack_out, reg_rd_wr_L_out out 1; reg_addr_out, reg_data_out, reg_src_out out 16
//  updates          in   NUM_CNTRS    per-counter event pulse
//  decrement        in   NUM_CNTRS    qualifies updates[i]: 1=-1, 0=+1
// BEHAVIOUR
//  Reset: all outputs 0; counters, deltas, drop flags and RR pointer cleared. Takes effect immediately.
//    Any in-flight ring transaction is discarded.
//  Ring pipeline: two registered stages (S1 capture, S2 output). Latency is 2 cycles for all traffic.
//    Accepts one transaction per cycle and preserves order.
//  Local hit: reg_req_in & ~reg_ack_in & addr[15:RAW]==TAG & idx=addr[RAW-1:0] <= NUM_CNTRS.
//    Non-hit transactions pass through unchanged, including ack.
//  Hit, idx<NUM_CNTRS, read: S2 drives ack=1, data=counter[idx]. Pending delta is not included.
//    If RESET_ON_READ=1, counter[idx]<=0 in S1; delta is kept.
//  Hit, idx<NUM_CNTRS, write: counter[idx]<=reg_data_in and delta[idx] cleared in S1. S2 returns ack=1,
//    data=written value.
//  Hit, idx==NUM_CNTRS (status): a read returns drop flags in bits [NUM_CNTRS-1:0], upper bits 0.
//    A write clears the flags whose data bits are 1 (W1C).
//  Port arbiter, per cycle: grant=RING if S1 holds a local counter hit, else FLUSH.
//  FLUSH: counter[ptr] += sign-extend(delta[ptr]), modulo 2^REG_WIDTH (wrap, no saturation).
//    delta[ptr] is cleared. ptr <= (ptr+1) mod NUM_CNTRS. Zero deltas are still visited.
//    A RING grant stalls ptr.
//  Accumulator per cycle: delta[i] += updates[i] ? (decrement[i] ? -1 : +1) : 0.
//    Limits are +/-(2^(DELTA_WIDTH-1)-1). An event that would exceed a limit is dropped and sets drop[i].
//  Same-cycle flush or ring write of counter i plus an update on i: the flush/write uses the old delta.
//    delta[i] then becomes exactly +/-1. No event is lost.
//  Max flush interval per counter with no ring hits: NUM_CNTRS cycles.
// TESTING
//  1 Pass-through: req, addr TAG+1, data 0xBEEF, src 3 -> identical fields on outputs 2 cycles later.
//    ack unchanged; no counter change.
//  2 Count up: 5 updates[0] (dec=0), idle 4 cycles, read idx0 -> ack=1, data=0x0005 at +2 cycles.
//  3 Wrap: write idx1=0x0000, one updates[1] with decrement[1]=1, idle 4, read idx1 -> 0xFFFF.
//  4 Saturation: back-to-back ring reads of idx1 for 20 cycles, updates[0] high throughout ->
//    delta[0] holds 7. Status read returns bit0=1; after reads stop, counter0=7.
//    Write status 0x0001 -> drop flags read back 0.
//  5 Collision: ring write idx0=0x0100 in the same cycle as updates[0] (+1); idle 4, read -> 0x0101.
//  6 Reset mid-op: assert reset while a local read is in S1 and delta[0]=3 -> next cycle all outputs 0.
//    After release, read idx0 -> 0x0000.

Source files
------------

// File: rtl/cntr_ring_scheduler.sv
// Ring-resident event counters: per-counter signed delta accumulators folded into the store by a round-robin flush
// that yields to local ring hits. Ring latency 2 cycles, one transaction per cycle, no backpressure.
module cntr_ring_scheduler #(
   parameter int NUM_CNTRS      = 2,
   parameter int REG_WIDTH      = 16,
   parameter int DELTA_WIDTH    = 4,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int TAG            = 0,
   parameter int RESET_ON_READ  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 reg_req_in,
   input  logic                 reg_ack_in,
   input  logic                 reg_rd_wr_L_in,
   input  logic [15:0]          reg_addr_in,
   input  logic [REG_WIDTH-1:0] reg_data_in,
   input  logic [15:0]          reg_src_in,
   output logic                 reg_req_out,
   output logic                 reg_ack_out,
   output logic                 reg_rd_wr_L_out,
   output logic [15:0]          reg_addr_out,
   output logic [REG_WIDTH-1:0] reg_data_out,
   output logic [15:0]          reg_src_out,
   input  logic [NUM_CNTRS-1:0] updates,
   input  logic [NUM_CNTRS-1:0] decrement
);
   localparam int PW = (NUM_CNTRS > 1) ? $clog2(NUM_CNTRS) : 1;
   localparam int TW = 16 - REG_ADDR_WIDTH;

   typedef logic [TW-1:0]                 tag_t;
   typedef logic [REG_ADDR_WIDTH:0]       idxw_t;
   typedef logic signed [DELTA_WIDTH-1:0] delta_t;

   localparam tag_t   TAG_V = tag_t'(TAG);
   localparam idxw_t  N_V   = idxw_t'(NUM_CNTRS);
   localparam delta_t D_ONE = delta_t'(1);
   localparam delta_t D_MAX = delta_t'((1 << (DELTA_WIDTH-1)) - 1);
   localparam delta_t D_MIN = -D_MAX;

   logic [REG_ADDR_WIDTH-1:0] in_idx;
   logic                      in_hit;

   logic                 s1_req, s1_ack, s1_rd, s1_cnt_hit, s1_sts_hit;
   logic [15:0]          s1_addr, s1_src;
   logic [REG_WIDTH-1:0] s1_data;
   logic [PW-1:0]        s1_cidx;

   logic [REG_WIDTH-1:0] cntr       [NUM_CNTRS];
   delta_t               delta      [NUM_CNTRS];
   delta_t               delta_base [NUM_CNTRS];
   delta_t               delta_nxt  [NUM_CNTRS];
   logic [NUM_CNTRS-1:0] drop, drop_set, drop_clr;
   logic [PW-1:0]        ptr;
   logic                 ring_grant, ring_wr;

   assign in_idx = reg_addr_in[REG_ADDR_WIDTH-1:0];
   assign in_hit = reg_req_in & ~reg_ack_in & (reg_addr_in[15:REG_ADDR_WIDTH] == TAG_V)
                 & ({1'b0, in_idx} <= N_V);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_req     <= 1'b0;
         s1_ack     <= 1'b0;
         s1_rd      <= 1'b0;
         s1_addr    <= '0;
         s1_data    <= '0;
         s1_src     <= '0;
         s1_cnt_hit <= 1'b0;
         s1_sts_hit <= 1'b0;
         s1_cidx    <= '0;
      end else begin
         s1_req     <= reg_req_in;
         s1_ack     <= reg_ack_in;
         s1_rd      <= reg_rd_wr_L_in;
         s1_addr    <= reg_addr_in;
         s1_data    <= reg_data_in;
         s1_src     <= reg_src_in;
         s1_cnt_hit <= in_hit & ({1'b0, in_idx} != N_V);
         s1_sts_hit <= in_hit & ({1'b0, in_idx} == N_V);
         s1_cidx    <= reg_addr_in[PW-1:0];
      end
   end

   // A counter hit in S1 owns the store port; otherwise the round-robin flush takes it.
   assign ring_grant = s1_cnt_hit;
   assign ring_wr    = s1_cnt_hit & ~s1_rd;
   assign drop_clr   = (s1_sts_hit & ~s1_rd) ? s1_data[NUM_CNTRS-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_req_out     <= 1'b0;
         reg_ack_out     <= 1'b0;
         reg_rd_wr_L_out <= 1'b0;
         reg_addr_out    <= '0;
         reg_data_out    <= '0;
         reg_src_out     <= '0;
      end else begin
         reg_req_out     <= s1_req;
         reg_ack_out     <= s1_ack | s1_cnt_hit | s1_sts_hit;
         reg_rd_wr_L_out <= s1_rd;
         reg_addr_out    <= s1_addr;
         reg_src_out     <= s1_src;
         if (s1_cnt_hit & s1_rd)
            reg_data_out <= cntr[s1_cidx];
         else if (s1_sts_hit & s1_rd)
            reg_data_out <= REG_WIDTH'(drop);
         else
            reg_data_out <= s1_data;
      end
   end

   // A delta being folded or overwritten this cycle restarts from zero, so a coincident event is kept.
   always_comb begin
      drop_set = '0;
      for (int i = 0; i < NUM_CNTRS; i++) begin
         delta_base[i] = (ring_wr ? (s1_cidx == PW'(i)) : (~ring_grant & (ptr == PW'(i))))
                       ? '0 : delta[i];
         delta_nxt[i]  = delta_base[i];
         if (updates[i]) begin
            if (decrement[i]) begin
               if (delta_base[i] == D_MIN) drop_set[i] = 1'b1;
               else                        delta_nxt[i] = delta_base[i] - D_ONE;
            end else begin
               if (delta_base[i] == D_MAX) drop_set[i] = 1'b1;
               else                        delta_nxt[i] = delta_base[i] + D_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CNTRS; i++) begin
            cntr[i]  <= '0;
            delta[i] <= '0;
         end
         drop <= '0;
         ptr  <= '0;
      end else begin
         for (int i = 0; i < NUM_CNTRS; i++)
            delta[i] <= delta_nxt[i];
         drop <= (drop & ~drop_clr) | drop_set;
         if (ring_grant) begin
            if (!s1_rd)
               cntr[s1_cidx] <= s1_data;
            else if (RESET_ON_READ != 0)
               cntr[s1_cidx] <= '0;
         end else begin
            cntr[ptr] <= cntr[ptr] + REG_WIDTH'(delta[ptr]);
            ptr       <= (ptr == PW'(NUM_CNTRS-1)) ? '0 : ptr + PW'(1);
         end
      end
   end
endmodule

// File: tb/tb_cntr_ring_scheduler.sv
// Bench for cntr_ring_scheduler: directed scenarios then random traffic, every cycle compared to a
// behavioural model of counters, deltas, drop flags and the ring pipeline.
module tb_cntr_ring_scheduler;
   localparam int N    = 2;
   localparam int RAW  = 5;
   localparam int TAG  = 0;
   localparam int ROR  = 0;
   localparam int DMAX = 7;

   logic          clk = 1'b0;
   logic          reset;
   logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
   logic [15:0]   reg_addr_in, reg_data_in, reg_src_in;
   logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
   logic [15:0]   reg_addr_out, reg_data_out, reg_src_out;
   logic [N-1:0]  updates, decrement;

   cntr_ring_scheduler #(
      .NUM_CNTRS(N), .REG_WIDTH(16), .DELTA_WIDTH(4), .REG_ADDR_WIDTH(RAW),
      .TAG(TAG), .RESET_ON_READ(ROR)
   ) dut (
      .clk(clk), .reset(reset),
      .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
      .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
      .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
      .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
      .updates(updates), .decrement(decrement)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: plain integers, counters kept modulo 2^16.
   int  m_cnt [N];
   int  m_dlt [N];
   bit  m_drop[N];
   int  m_ptr;
   bit  s_req, s_ack, s_rd;
   int  s_addr, s_data, s_src;
   logic [50:0] exp_out;

   function automatic logic [50:0] ring_obs();
      return {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};
   endfunction

   function automatic logic [15:0] cnt_addr(input int idx);
      return 16'((TAG << RAW) | idx);
   endfunction

   function automatic int drop_word();
      int w = 0;
      for (int i = 0; i < N; i++) if (m_drop[i]) w = w | (1 << i);
      return w;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_dlt[i] = 0; m_drop[i] = 0;
      end
      m_ptr = 0;
      s_req = 0; s_ack = 0; s_rd = 0; s_addr = 0; s_data = 0; s_src = 0;
   endtask

   // One clock of the behavioural model; sets exp_out to what the ring must show after this edge.
   task automatic model_step();
      int idx, ed, base, nv;
      bit hit;
      bit clr[N];
      idx = s_addr % (1 << RAW);
      hit = s_req && !s_ack && ((s_addr >> RAW) == TAG) && (idx <= N);
      ed  = s_data;
      if (hit && s_rd) ed = (idx < N) ? m_cnt[idx] : drop_word();
      exp_out = {s_req, s_ack | hit, s_rd, 16'(s_addr), 16'(ed), 16'(s_src)};
      for (int i = 0; i < N; i++) clr[i] = 0;
      if (hit && idx < N) begin
         if (!s_rd) begin
            m_cnt[idx] = s_data;
            clr[idx]   = 1;
         end else if (ROR != 0) begin
            m_cnt[idx] = 0;
         end
      end else begin
         m_cnt[m_ptr] = (m_cnt[m_ptr] + m_dlt[m_ptr]) & 32'hFFFF;
         clr[m_ptr]   = 1;
         m_ptr        = (m_ptr + 1) % N;
      end
      if (hit && idx == N && !s_rd)
         for (int i = 0; i < N; i++) if (((s_data >> i) & 1) == 1) m_drop[i] = 0;
      for (int i = 0; i < N; i++) begin
         base = clr[i] ? 0 : m_dlt[i];
         if (updates[i]) begin
            nv = base + (decrement[i] ? -1 : 1);
            if (nv > DMAX || nv < -DMAX) begin
               m_drop[i] = 1;
               m_dlt[i]  = base;
            end else begin
               m_dlt[i] = nv;
            end
         end else begin
            m_dlt[i] = base;
         end
      end
      s_req = reg_req_in; s_ack = reg_ack_in; s_rd = reg_rd_wr_L_in;
      s_addr = int'(reg_addr_in); s_data = int'(reg_data_in); s_src = int'(reg_src_in);
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check(tag, 64'(ring_obs()), 64'(exp_out));
   endtask

   task automatic clear_ring();
      reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
      reg_addr_in = 0; reg_data_in = 0; reg_src_in = 0;
   endtask

   task automatic idle(input int n);
      clear_ring();
      updates = 0; decrement = 0;
      repeat (n) cycle("idle");
   endtask

   task automatic ring_txn(input bit rd, input int idx, input logic [15:0] data, input string tag);
      reg_req_in = 1; reg_ack_in = 0; reg_rd_wr_L_in = rd;
      reg_addr_in = cnt_addr(idx); reg_data_in = data; reg_src_in = 16'h0011;
      cycle(tag);
      clear_ring();
   endtask

   task automatic rd_chk(input int idx, input logic [15:0] exp, input string tag);
      ring_txn(1, idx, 16'h0000, tag);
      cycle(tag);
      check(tag, 64'({reg_ack_out, reg_data_out}), 64'({1'b1, exp}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1;
      clear_ring();
      updates = 0; decrement = 0;
      model_reset();
      @(posedge clk);
      #1;
      check("reset_state", 64'(ring_obs()), 64'd0);
      @(posedge clk);
      #1;
      reset = 0;

      // Pass-through of a foreign tag
      reg_req_in = 1; reg_ack_in = 0; reg_rd_wr_L_in = 1;
      reg_addr_in = 16'((TAG + 1) << RAW); reg_data_in = 16'hBEEF; reg_src_in = 16'h0003;
      cycle("pass_s1");
      clear_ring();
      cycle("pass_s2");
      check("pass_through", 64'(ring_obs()), 64'({1'b1, 1'b0, 1'b1, 16'((TAG + 1) << RAW), 16'hBEEF, 16'h0003}));

      // Count up
      updates = 2'b01; decrement = 2'b00;
      repeat (5) cycle("count_up_upd");
      idle(4);
      rd_chk(0, 16'h0005, "count_up");

      // Wrap below zero: event lands in the write's S1 cycle
      ring_txn(0, 1, 16'h0000, "wrap_wr");
      updates = 2'b10; decrement = 2'b10;
      cycle("wrap_upd");
      idle(4);
      rd_chk(1, 16'hFFFF, "wrap");

      // Saturation while ring reads stall the flush
      ring_txn(0, 0, 16'h0000, "sat_clr");
      idle(4);
      reg_req_in = 1; reg_rd_wr_L_in = 1; reg_addr_in = cnt_addr(1); reg_src_in = 16'h0022;
      updates = 2'b01; decrement = 2'b00;
      repeat (20) cycle("sat_reads");
      idle(1);
      rd_chk(N, 16'h0001, "sat_status");
      idle(4);
      rd_chk(0, 16'h0007, "sat_count");
      ring_txn(0, N, 16'h0001, "sts_w1c");
      idle(1);
      rd_chk(N, 16'h0000, "sts_cleared");

      // Write colliding with an event on the same counter
      ring_txn(0, 0, 16'h0100, "coll_wr");
      updates = 2'b01; decrement = 2'b00;
      cycle("coll_upd");
      idle(4);
      rd_chk(0, 16'h0101, "collision");

      // Reset while a local read sits in S1 with delta[0] at 3
      idle(2);
      reg_req_in = 1; reg_rd_wr_L_in = 1; reg_addr_in = cnt_addr(1);
      updates = 2'b00;
      cycle("rst_rd0");
      updates = 2'b01;
      repeat (3) cycle("rst_rd");
      reset = 1;
      clear_ring();
      updates = 0;
      #1;
      check("reset_mid_op", 64'(ring_obs()), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 0;
      idle(4);
      rd_chk(0, 16'h0000, "post_reset");

      // Random traffic against the model
      for (int k = 0; k < 800; k++) begin
         int tg;
         reg_req_in     = ($urandom_range(0, 9) < 5);
         reg_ack_in     = ($urandom_range(0, 7) == 0);
         reg_rd_wr_L_in = $urandom_range(0, 1) == 1;
         tg             = ($urandom_range(0, 7) == 0) ? TAG + 1 : TAG;
         reg_addr_in    = 16'((tg << RAW) | $urandom_range(0, 3));
         reg_data_in    = 16'($urandom);
         reg_src_in     = 16'($urandom);
         updates        = N'($urandom);
         decrement      = N'($urandom);
         cycle("random");
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
